// File: rtl/instr_pkg.sv
// Shared constants and mode encoding for the instruction encoder/decoder pair.
package instr_pkg;

    localparam int MODE_W    = 2;
    localparam int OPERAND_W = 6;
    localparam int INSTR_W   = 8;

    localparam logic [MODE_W-1:0] MODE0 = 2'd0;
    localparam logic [MODE_W-1:0] MODE1 = 2'd1;
    localparam logic [MODE_W-1:0] MODE2 = 2'd2;
    localparam logic [MODE_W-1:0] MODE3 = 2'd3;

    // Returns {legal, code}; anything other than exactly one hot bit is illegal.
    function automatic logic [MODE_W:0] encode_onehot(input logic [3:0] onehot);
        case (onehot)
            4'b0001: return {1'b1, MODE0};
            4'b0010: return {1'b1, MODE1};
            4'b0100: return {1'b1, MODE2};
            4'b1000: return {1'b1, MODE3};
            default: return {1'b0, MODE0};
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy tracking and a registered head output.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [LW-1:0]    level_after_pop;
    logic             do_push;
    logic             do_pop;

    assign full            = (level == LW'(DEPTH));
    assign empty           = (level == '0);
    assign do_push         = push && !full;
    assign do_pop          = pop && !empty;
    assign rd_next         = rd_ptr + AW'(do_pop);
    assign level_after_pop = level - LW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // rdata is preloaded with whatever will be the head after this edge, so a
    // push into an empty FIFO is visible one cycle later without a bypass path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            level  <= level_after_pop + LW'(do_push);
            if (level_after_pop != '0) begin
                rdata <= mem[rd_next];
            end else if (do_push) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs one-hot mode strobes and an operand into 8-bit instructions, buffered
// and streamed out over valid/ready; illegal mode vectors are dropped and counted.
module instruction_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode0,
    input  logic                    mode1,
    input  logic                    mode2,
    input  logic                    mode3,
    input  logic [OPERAND_W-1:0]    operand,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INSTR_W-1:0]      instruction,
    output logic                    err_pulse,
    output logic [ERRW-1:0]         err_count,
    output logic [15:0]             issued_count,
    output logic [$clog2(DEPTH):0]  level
);

    logic [MODE_W:0] enc;
    logic            legal;
    logic            accept;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;

    assign enc       = encode_onehot({mode3, mode2, mode1, mode0});
    assign legal     = enc[MODE_W];
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({enc[MODE_W-1:0], operand}),
        .pop   (pop),
        .rdata (instruction),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse    <= 1'b0;
            err_count    <= '0;
            issued_count <= '0;
        end else begin
            err_pulse <= accept && !legal;
            if (accept && !legal && (err_count != '1)) begin
                err_count <= err_count + ERRW'(1);
            end
            if (pop) begin
                issued_count <= issued_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed and randomized bench for instruction_encoder against a queue-based model.
module tb_instruction_encoder;

    localparam int DEPTH = 4;
    localparam int ERRW  = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               mode_v;
    logic [5:0]               operand;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               instruction;
    logic                     err_pulse;
    logic [ERRW-1:0]          err_count;
    logic [15:0]              issued_count;
    logic [$clog2(DEPTH):0]   level;

    always #5 clk = ~clk;

    instruction_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mode0        (mode_v[0]),
        .mode1        (mode_v[1]),
        .mode2        (mode_v[2]),
        .mode3        (mode_v[3]),
        .operand      (operand),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .instruction  (instruction),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .issued_count (issued_count),
        .level        (level)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]      q[$];
    logic [7:0]      m_instr  = 8'h00;
    logic [ERRW-1:0] m_err    = '0;
    logic [15:0]     m_issued = 16'd0;
    logic            m_pulse  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] m, input logic [5:0] op, input bit ordy);
        in_valid  = v;
        mode_v    = m;
        operand   = op;
        out_ready = ordy;
    endtask

    // Advance one clock: update the model from the pre-edge inputs, then compare.
    task automatic step();
        bit         acc;
        bit         pp;
        bit         legal;
        logic [1:0] code;
        if (rst) begin
            q.delete();
            m_instr  = 8'h00;
            m_err    = '0;
            m_issued = 16'd0;
            m_pulse  = 1'b0;
        end else begin
            acc   = in_valid && (q.size() != DEPTH);
            pp    = out_ready && (q.size() != 0);
            legal = ($countones(mode_v) == 1);
            code  = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (mode_v[i]) code = 2'(i);
            end
            m_pulse = acc && !legal;
            if (pp) begin
                void'(q.pop_front());
                m_issued = m_issued + 16'd1;
            end
            if (acc && legal) q.push_back({code, operand});
            if (m_pulse && (m_err != '1)) m_err = m_err + 1'b1;
            if (q.size() != 0) m_instr = q[0];
        end
        @(posedge clk);
        #1;
        check("out_valid",    out_valid,    q.size() != 0);
        check("level",        level,        q.size());
        check("in_ready",     in_ready,     q.size() != DEPTH);
        check("instruction",  instruction,  m_instr);
        check("err_pulse",    err_pulse,    m_pulse);
        check("err_count",    err_count,    m_err);
        check("issued_count", issued_count, m_issued);
    endtask

    initial begin
        logic [7:0] seq [4];
        int         guard;
        logic [3:0] rm;

        rst = 1'b1;
        drive(0, 4'b0000, 6'h00, 0);
        step();
        step();
        check("reset_instr", instruction, 8'h00);
        check("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        // single transfer, mode2 / 0x15
        drive(1, 4'b0100, 6'h15, 1);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_instr", instruction, 8'h95);
        drive(0, 4'b0000, 6'h00, 1);
        step();
        check("t1_issued", issued_count, 1);
        check("t1_level", level, 0);

        // fill with all four modes, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(1 << i), 6'h3F, 0);
            step();
        end
        drive(0, 4'b0000, 6'h00, 0);
        step();
        check("t2_level", level, 4);
        check("t2_in_ready", in_ready, 0);
        seq[0] = 8'h3F; seq[1] = 8'h7F; seq[2] = 8'hBF; seq[3] = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_order", instruction, seq[i]);
            step();
        end
        check("t2_empty", out_valid, 0);

        // illegal vectors
        drive(1, 4'b0000, 6'h11, 0);
        step();
        check("t3_pulse0", err_pulse, 1);
        drive(1, 4'b0101, 6'h22, 0);
        step();
        check("t3_pulse1", err_pulse, 1);
        check("t3_count", err_count, 2);
        drive(0, 4'b0000, 6'h00, 0);
        step();
        check("t3_pulse_clr", err_pulse, 0);
        check("t3_no_push", out_valid, 0);

        // full with simultaneous request and pop
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'b0010, 6'(i), 0);
            step();
        end
        drive(1, 4'b0001, 6'h2A, 1);
        step();
        check("t4_pop_only", level, 3);
        out_ready = 1'b0;
        step();
        check("t4_refill", level, 4);
        drive(0, 4'b0000, 6'h00, 1);
        for (int i = 0; i < 5; i++) step();

        // issued_count wrap
        guard = 0;
        drive(1, 4'b1000, 6'h01, 1);
        step();
        while (m_issued != 16'd0 && guard < 70000) begin
            operand = 6'($urandom);
            step();
            guard++;
        end
        check("t5_wrap_bound", guard < 70000, 1);
        check("t5_wrapped", issued_count, 16'd0);
        drive(0, 4'b0000, 6'h00, 1);
        for (int i = 0; i < 3; i++) step();

        // err_count saturation
        for (int i = 0; i < 260; i++) begin
            drive(1, 4'b1111, 6'($urandom), 1);
            step();
        end
        check("t5_saturate", err_count, 8'hFF);

        // reset with three entries buffered
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b0100, 6'(i + 5), 0);
            step();
        end
        check("t6_level3", level, 3);
        drive(0, 4'b0000, 6'h00, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_level", level, 0);
        check("t6_valid", out_valid, 0);
        check("t6_err", err_count, 0);
        check("t6_issued", issued_count, 0);
        for (int i = 0; i < 3; i++) step();
        check("t6_no_emit", issued_count, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, rm, 6'($urandom), $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Accepts one-hot mode strobes plus a 6-bit operand and packs them into 8-bit instructions in the format {mode[1:0], operand[5:0]}. Mode 0 encodes as 2'b00, up to mode 3 as 2'b11.
Encoded instructions are buffered in a small FIFO and emitted over a valid/ready stream. The block sits upstream of instruction_decoder and is its producer side.
Illegal mode vectors (not exactly one-hot) are consumed, dropped and counted.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of two and at least 2
ERRW, 8, width of the saturating illegal-request counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
mode0  input  1  select mode 0
mode1  input  1  select mode 1
mode2  input  1  select mode 2
mode3  input  1  select mode 3
operand  input  6  payload placed in instruction[5:0]
out_valid  output  1  instruction present on the instruction output
out_ready  input  1  consumer accepts the instruction
instruction  output  8  encoded instruction {mode code, operand}
err_pulse  output  1  one-cycle pulse when an illegal request was consumed
err_count  output  ERRW  saturating count of illegal requests
issued_count  output  16  wrapping count of instructions accepted downstream
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge. rst has priority over all other activity.
- Reset values:
  - FIFO emptied; read and write pointers at 0.
  - level=0, out_valid=0, instruction=8'h00.
  - in_ready=1, err_pulse=0, err_count=0, issued_count=0.
- in_ready = (level != DEPTH). It is a function of registered state only and has no combinational path from out_ready.
- Input handshake: a request is accepted when in_valid && in_ready at a clock edge.
- Legality: a request is legal only if exactly one of mode0..mode3 is 1.
  - Legal accepted request: push {code, operand} into the FIFO. code is 00/01/10/11 for mode0/1/2/3.
  - Illegal accepted request: nothing is pushed. err_pulse=1 in the following cycle and err_count increments, saturating at all-ones.
- Output side:
  - out_valid = (level != 0).
  - instruction = FIFO head, registered. Latency from accept to out_valid is 1 cycle when the FIFO was empty.
  - instruction holds stable while out_valid && !out_ready.
  - When out_valid is 0, instruction holds its last value (8'h00 after reset).
- Output handshake: a pop occurs when out_valid && out_ready. Each pop increments issued_count, wrapping 16'hFFFF to 0.
- Simultaneous push and pop:
  - When 0 < level < DEPTH: level unchanged and pointers both advance.
  - When full: in_ready=0, so no push happens; the pop frees a slot and in_ready is 1 in the next cycle.
  - When empty: no pop is possible. The push is visible in the next cycle (no bypass).
- Pointers are log2(DEPTH) bits and wrap naturally. level is tracked explicitly, which distinguishes full from empty.
- Reset mid-operation: all buffered instructions are discarded and no output handshake completes in the reset cycle. Counters clear.
- No FSM beyond the FIFO occupancy. err_pulse is cleared every cycle unless re-set.

Decomposition:
- Shared package instr_pkg holds:
  - MODE_W=2, OPERAND_W=6, INSTR_W=8.
  - Mode code constants MODE0..MODE3 = 2'd0..2'd3.
  - An encode function, onehot4 -> {legal, code}.
- instruction_decoder uses the same package constants.
- One natural sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/level). The encoder wraps it with the legality check, encode logic and counters.

Test Plan:
- Reset then push mode2=1, operand=6'h15 with out_ready=1 -> out_valid=1 one cycle later with instruction=8'h95; then issued_count=1 and level=0.
- Push four legal requests, modes 0,1,2,3 with operand=6'h3F, while out_ready=0 -> level=4, in_ready=0. Then set out_ready=1 -> instructions 8'h3F, 8'h7F, 8'hBF, 8'hFF are emitted in order.
- Illegal vectors: mode=4'b0000, then 4'b0101 -> each is consumed (in_ready=1) with no push, err_pulse high one cycle each, err_count=2, out_valid stays 0.
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> exactly one pop with no push that cycle; the push lands in the next cycle and level returns to 4.
- 65536 consecutive legal transfers -> issued_count wraps to 0. 256+ illegal requests with ERRW=8 -> err_count holds at 8'hFF.
- Assert rst with level=3 and out_ready=1 -> in the next cycle level=0, out_valid=0, counters 0, and none of the three entries are emitted.
